// File: rtl/ccip_c0_rd_mux_if.sv
// CCI-P c0 read-channel bundle: per-port requestor side, host Tx/Rx c0 side
// and the demuxed response side, as seen by the read mux.
interface ccip_c0_rd_mux_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 42,
  parameter int MDATA_W   = 16,
  parameter int DATA_W    = 512
);
  logic [NUM_PORTS-1:0]         req_valid;
  logic [NUM_PORTS*ADDR_W-1:0]  req_addr;
  logic [NUM_PORTS*MDATA_W-1:0] req_mdata;
  logic [NUM_PORTS-1:0]         req_ready;
  logic                         tx_c0_valid;
  logic [ADDR_W-1:0]            tx_c0_addr;
  logic [MDATA_W-1:0]           tx_c0_mdata;
  logic                         tx_c0_almfull;
  logic                         rx_c0_valid;
  logic [MDATA_W-1:0]           rx_c0_mdata;
  logic [DATA_W-1:0]            rx_c0_data;
  logic [NUM_PORTS-1:0]         rsp_valid;
  logic [MDATA_W-1:0]           rsp_mdata;
  logic [DATA_W-1:0]            rsp_data;

  modport slave (
    input  req_valid, req_addr, req_mdata, tx_c0_almfull,
           rx_c0_valid, rx_c0_mdata, rx_c0_data,
    output req_ready, tx_c0_valid, tx_c0_addr, tx_c0_mdata,
           rsp_valid, rsp_mdata, rsp_data
  );

  modport master (
    output req_valid, req_addr, req_mdata, tx_c0_almfull,
           rx_c0_valid, rx_c0_mdata, rx_c0_data,
    input  req_ready, tx_c0_valid, tx_c0_addr, tx_c0_mdata,
           rsp_valid, rsp_mdata, rsp_data
  );
endinterface

// File: rtl/ccip_c0_rd_mux.sv
// N-to-1 CCI-P c0 read mux: round-robin request arbitration with per-port
// credit limits, mdata port tagging and tag-based response routing.
module ccip_c0_rd_mux #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 64,
  parameter int PORT_ID_W       = $clog2(NUM_PORTS),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       pClk,
  input  logic                       pReset,
  ccip_c0_rd_mux_if.slave            bus,
  output logic [NUM_PORTS*CNT_W-1:0] outstanding,
  output logic                       idle,
  output logic                       err_unexpected_rsp
);
  localparam int               USER_W  = MDATA_W - PORT_ID_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
  logic [USER_W-1:0]    user_arr [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_q    [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d    [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible, has_credit, rsp_hit, ready_c;
  logic [PORT_ID_W-1:0] prio_q, prio_d, grant_idx, rsp_port;
  logic                 grant_found, accept, rsp_ok, rsp_bad, unused_tag_bits;

  logic                 tx_valid_q;
  logic [ADDR_W-1:0]    tx_addr_q;
  logic [MDATA_W-1:0]   tx_mdata_q;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [MDATA_W-1:0]   rsp_mdata_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 err_q;

  function automatic logic [PORT_ID_W-1:0] wrap_add(input logic [PORT_ID_W-1:0] base,
                                                    input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return PORT_ID_W'(sum);
  endfunction

  assign rsp_port = bus.rx_c0_mdata[MDATA_W-1 -: PORT_ID_W];

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    unused_tag_bits = 1'b0;
    idle            = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]   = bus.req_addr[i*ADDR_W +: ADDR_W];
      user_arr[i]   = bus.req_mdata[i*MDATA_W +: USER_W];
      unused_tag_bits = unused_tag_bits ^ (^bus.req_mdata[i*MDATA_W+USER_W +: PORT_ID_W]);
      eligible[i]   = bus.req_valid[i] && (cnt_q[i] < MAX_CNT);
      has_credit[i] = (cnt_q[i] != '0);
      rsp_hit[i]    = (rsp_port == PORT_ID_W'(i));
      outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
      if (cnt_q[i] != '0) idle = 1'b0;
    end
  end

  // Round-robin search starting at the port after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!grant_found && eligible[wrap_add(prio_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(prio_q, k);
      end
    end
    accept  = grant_found && !bus.tx_c0_almfull && !pReset;
    ready_c = '0;
    if (accept) ready_c[grant_idx] = 1'b1;
    prio_d  = accept ? wrap_add(grant_idx, 1) : prio_q;
  end

  // A response is only legal for an existing port with a read in flight.
  assign rsp_ok  = bus.rx_c0_valid && |(rsp_hit & has_credit);
  assign rsp_bad = bus.rx_c0_valid && !rsp_ok;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ready_c[i] && !(rsp_ok && rsp_hit[i]))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!ready_c[i] && rsp_ok && rsp_hit[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      prio_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_mdata_q  <= '0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset like any other register; in-flight state must not survive reset.
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      prio_q      <= prio_d;
      tx_valid_q  <= accept;
      if (accept) begin
        tx_addr_q  <= addr_arr[grant_idx];
        tx_mdata_q <= {grant_idx, user_arr[grant_idx]};
      end
      rsp_valid_q <= rsp_ok ? rsp_hit : '0;
      if (rsp_ok) begin
        rsp_mdata_q <= {{PORT_ID_W{1'b0}}, bus.rx_c0_mdata[USER_W-1:0]};
        rsp_data_q  <= bus.rx_c0_data;
      end
      if (rsp_bad) err_q <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.req_ready       = ready_c;
  assign bus.tx_c0_valid     = tx_valid_q;
  assign bus.tx_c0_addr      = tx_addr_q;
  assign bus.tx_c0_mdata     = tx_mdata_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_mdata       = rsp_mdata_q;
  assign bus.rsp_data        = rsp_data_q;
  assign err_unexpected_rsp  = err_q;
endmodule

// File: tb/tb_ccip_c0_rd_mux.sv
// Directed bench for ccip_c0_rd_mux: dut_a uses the default credit limit,
// dut_b a limit of 2 for the credit-exhaustion scenario.
module tb_ccip_c0_rd_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [27:0] outstanding_a;
  logic [7:0]  outstanding_b;
  logic        idle_a, idle_b, err_a, err_b;

  ccip_c0_rd_mux_if bus_a ();
  ccip_c0_rd_mux_if bus_b ();

  ccip_c0_rd_mux #(.NUM_PORTS(4), .MAX_OUTSTANDING(64)) dut_a (
    .pClk(clk), .pReset(rst), .bus(bus_a),
    .outstanding(outstanding_a), .idle(idle_a), .err_unexpected_rsp(err_a)
  );

  ccip_c0_rd_mux #(.NUM_PORTS(4), .MAX_OUTSTANDING(2)) dut_b (
    .pClk(clk), .pReset(rst), .bus(bus_b),
    .outstanding(outstanding_b), .idle(idle_b), .err_unexpected_rsp(err_b)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] cnt_a(input int p);
    return outstanding_a[p*7 +: 7];
  endfunction

  function automatic logic [1:0] cnt_b(input int p);
    return outstanding_b[p*2 +: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_rsp_a(input int p, input logic [13:0] user);
    bus_a.rx_c0_valid = 1'b1;
    bus_a.rx_c0_mdata = {p[1:0], user};
    tick();
    bus_a.rx_c0_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.req_valid = 4'hF;
    tick();
    checks++; if (bus_a.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", bus_a.req_ready); end
    checks++; if (bus_a.tx_c0_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b exp 0", bus_a.tx_c0_valid); end
    checks++; if (bus_a.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", bus_a.rsp_valid); end
    checks++; if (outstanding_a !== 28'd0) begin errors++; $display("FAIL reset_outstanding: got %h exp 0", outstanding_a); end
    checks++; if (idle_a !== 1'b1 || idle_b !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b%b exp 11", idle_a, idle_b); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_a); end
    bus_a.req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [511:0] d;
    d = {16{32'hCAFE_F00D}};
    bus_a.req_valid = 4'b0100;
    bus_a.req_addr[2*42 +: 42]  = 42'h100;
    bus_a.req_mdata[2*16 +: 16] = 16'h0ABC;
    #1;
    checks++; if (bus_a.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", bus_a.req_ready); end
    tick();
    bus_a.req_valid = 4'b0000;
    checks++; if (bus_a.tx_c0_valid !== 1'b1 || bus_a.tx_c0_addr !== 42'h100) begin errors++; $display("FAIL single_tx: got v=%b a=%h exp v=1 a=100", bus_a.tx_c0_valid, bus_a.tx_c0_addr); end
    checks++; if (bus_a.tx_c0_mdata !== 16'h8ABC) begin errors++; $display("FAIL single_tx_mdata: got %h exp 8abc", bus_a.tx_c0_mdata); end
    checks++; if (cnt_a(2) !== 7'd1 || idle_a !== 1'b0) begin errors++; $display("FAIL single_cnt: got %0d idle=%b exp 1 idle=0", cnt_a(2), idle_a); end
    tick();
    checks++; if (bus_a.tx_c0_valid !== 1'b0) begin errors++; $display("FAIL single_tx_pulse: got %b exp 0", bus_a.tx_c0_valid); end
    bus_a.rx_c0_data = d;
    send_rsp_a(2, 14'h0ABC);
    checks++; if (bus_a.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0100", bus_a.rsp_valid); end
    checks++; if (bus_a.rsp_mdata !== 16'h0ABC) begin errors++; $display("FAIL single_rsp_mdata: got %h exp 0abc", bus_a.rsp_mdata); end
    checks++; if (bus_a.rsp_data !== d) begin errors++; $display("FAIL single_rsp_data: got %h exp %h", bus_a.rsp_data[31:0], d[31:0]); end
    checks++; if (cnt_a(2) !== 7'd0 || idle_a !== 1'b1) begin errors++; $display("FAIL single_drain: got %0d idle=%b exp 0 idle=1", cnt_a(2), idle_a); end
    tick();
    checks++; if (bus_a.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse: got %b exp 0000", bus_a.rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready;
    do_reset();
    bus_a.req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      exp_ready = 4'b0001 << (c % 4);
      #1;
      checks++; if (bus_a.req_ready !== exp_ready) begin errors++; $display("FAIL fair_grant%0d: got %b exp %b", c, bus_a.req_ready, exp_ready); end
      tick();
    end
    bus_a.req_valid = 4'h0;
    for (int p = 0; p < 4; p++) begin
      checks++; if (cnt_a(p) !== 7'd2) begin errors++; $display("FAIL fair_cnt%0d: got %0d exp 2", p, cnt_a(p)); end
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) send_rsp_a(p, 14'h0);
    checks++; if (idle_a !== 1'b1 || err_a !== 1'b0) begin errors++; $display("FAIL fair_drain: got idle=%b err=%b exp idle=1 err=0", idle_a, err_a); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ready;
    logic       af;
    bus_a.req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      af = (c >= 3 && c <= 6);
      bus_a.tx_c0_almfull = af;
      exp_ready = af ? 4'b0000 : (c < 3 ? 4'b0001 << c : 4'b1000);
      #1;
      checks++; if (bus_a.req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready%0d: got %b exp %b", c, bus_a.req_ready, exp_ready); end
      tick();
      checks++; if (bus_a.tx_c0_valid !== !af) begin errors++; $display("FAIL bp_tx%0d: got %b exp %b", c + 1, bus_a.tx_c0_valid, !af); end
    end
    bus_a.req_valid = 4'h0;
    bus_a.tx_c0_almfull = 1'b0;
    checks++; if (outstanding_a !== {7'd1, 7'd1, 7'd1, 7'd1}) begin errors++; $display("FAIL bp_cnt: got %h exp %h", outstanding_a, {7'd1, 7'd1, 7'd1, 7'd1}); end
    for (int p = 0; p < 4; p++) send_rsp_a(p, 14'h0);
  endtask

  task automatic test_credit_limit();
    bus_b.req_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus_b.req_ready !== 4'b0001) begin errors++; $display("FAIL credit_accept%0d: got %b exp 0001", c, bus_b.req_ready); end
      tick();
    end
    #1;
    checks++; if (bus_b.req_ready !== 4'b0000 || cnt_b(0) !== 2'd2) begin errors++; $display("FAIL credit_full: got %b cnt=%0d exp 0000 cnt=2", bus_b.req_ready, cnt_b(0)); end
    tick();
    bus_b.req_valid = 4'b0011;
    #1;
    checks++; if (bus_b.req_ready !== 4'b0010) begin errors++; $display("FAIL credit_other: got %b exp 0010", bus_b.req_ready); end
    tick();
    bus_b.req_valid   = 4'b0001;
    bus_b.rx_c0_valid = 1'b1;
    bus_b.rx_c0_mdata = 16'h0000;
    #1;
    checks++; if (bus_b.req_ready !== 4'b0000) begin errors++; $display("FAIL credit_still_full: got %b exp 0000", bus_b.req_ready); end
    tick();
    bus_b.rx_c0_valid = 1'b0;
    checks++; if (bus_b.rsp_valid !== 4'b0001 || cnt_b(0) !== 2'd1) begin errors++; $display("FAIL credit_rsp: got %b cnt=%0d exp 0001 cnt=1", bus_b.rsp_valid, cnt_b(0)); end
    #1;
    checks++; if (bus_b.req_ready !== 4'b0001) begin errors++; $display("FAIL credit_reenable: got %b exp 0001", bus_b.req_ready); end
    tick();
    bus_b.req_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    bus_a.req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) tick();
    checks++; if (cnt_a(1) !== 7'd3) begin errors++; $display("FAIL b2b_prefill: got %0d exp 3", cnt_a(1)); end
    bus_a.rx_c0_valid = 1'b1;
    bus_a.rx_c0_mdata = 16'h4055;
    tick();
    bus_a.req_valid   = 4'b0000;
    bus_a.rx_c0_valid = 1'b0;
    checks++; if (cnt_a(1) !== 7'd3) begin errors++; $display("FAIL b2b_cnt: got %0d exp 3", cnt_a(1)); end
    checks++; if (bus_a.tx_c0_valid !== 1'b1 || bus_a.rsp_valid !== 4'b0010) begin errors++; $display("FAIL b2b_pulses: got tx=%b rsp=%b exp tx=1 rsp=0010", bus_a.tx_c0_valid, bus_a.rsp_valid); end
    checks++; if (bus_a.rsp_mdata !== 16'h0055) begin errors++; $display("FAIL b2b_rsp_mdata: got %h exp 0055", bus_a.rsp_mdata); end
    for (int r = 0; r < 3; r++) send_rsp_a(1, 14'h0);
    checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL b2b_drain: got idle=%b exp 1", idle_a); end
  endtask

  task automatic test_error();
    bus_a.req_valid   = 4'b0001;
    bus_a.rx_c0_valid = 1'b1;
    bus_a.rx_c0_mdata = 16'h0123;
    tick();
    bus_a.req_valid   = 4'b0000;
    bus_a.rx_c0_valid = 1'b0;
    checks++; if (bus_a.rsp_valid !== 4'b0000 || err_a !== 1'b1) begin errors++; $display("FAIL err_drop: got rsp=%b err=%b exp rsp=0000 err=1", bus_a.rsp_valid, err_a); end
    checks++; if (cnt_a(0) !== 7'd1) begin errors++; $display("FAIL err_cnt: got %0d exp 1", cnt_a(0)); end
    tick();
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err_a); end
    bus_a.req_valid = 4'b0001;
    tick();
    bus_a.req_valid = 4'b0000;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (err_a !== 1'b0 || bus_a.tx_c0_valid !== 1'b0) begin errors++; $display("FAIL async_rst: got err=%b tx=%b exp 0 0", err_a, bus_a.tx_c0_valid); end
    checks++; if (outstanding_a !== 28'd0 || idle_a !== 1'b1) begin errors++; $display("FAIL async_rst_cnt: got %h idle=%b exp 0 idle=1", outstanding_a, idle_a); end
    tick();
    rst = 1'b0;
    send_rsp_a(0, 14'h0);
    checks++; if (err_a !== 1'b1 || bus_a.rsp_valid !== 4'b0000) begin errors++; $display("FAIL stale_rsp: got err=%b rsp=%b exp err=1 rsp=0000", err_a, bus_a.rsp_valid); end
  endtask

  initial begin
    bus_a.req_valid = '0; bus_a.req_addr = '0; bus_a.req_mdata = '0;
    bus_a.tx_c0_almfull = 1'b0; bus_a.rx_c0_valid = 1'b0;
    bus_a.rx_c0_mdata = '0; bus_a.rx_c0_data = '0;
    bus_b.req_valid = '0; bus_b.req_addr = '0; bus_b.req_mdata = '0;
    bus_b.tx_c0_almfull = 1'b0; bus_b.rx_c0_valid = 1'b0;
    bus_b.rx_c0_mdata = '0; bus_b.rx_c0_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_credit_limit();
    test_back_to_back();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
